// File: rtl/mem_responder_if.sv
// Purpose: request/response handshake bundle between an initiator and mem_responder.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata carry one load or store request;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err carry its single response back.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Initiator side: drives requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Purpose: single-outstanding word memory (DEPTH x 32b at BASE) answering lw/sw requests.
// Latency: response valid exactly LATENCY cycles after the accepting edge.
// Backpressure: req_ready only in IDLE; a response is held stable until rsp_ready.
// Ports: clk, rst (sync, active-high); bus = slave side of mem_responder_if.
module mem_responder #(
  parameter logic [31:0] BASE    = 32'h10010000,
  parameter int          DEPTH   = 256,
  parameter int          LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int          IDXW     = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [31:0]     acc_off;
  logic            acc_err;
  logic [IDXW-1:0] acc_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0)   state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // With LATENCY=1 the access happens on the accepting edge itself, before the
  // capture registers are loaded, so the live request is used in that case.
  assign acc_we    = (state == IDLE) ? bus.req_we    : cap_we;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;

  // Offset wraps at 32 bits, so addresses below BASE land far out of range.
  assign acc_off = acc_addr - BASE;
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_off >= SPAN);
  assign acc_idx = acc_off[IDXW+1:2];

  // Countdown, request capture, memory and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        if (acc_err) begin
          rdata_q <= ERR_DATA;
          err_q   <= 1'b1;
        end else begin
          err_q <= 1'b0;
          if (acc_we) begin
            mem[acc_idx] <= acc_wdata;
            rdata_q      <= acc_wdata;
          end else begin
            rdata_q <= mem[acc_idx];
          end
        end
      end
    end
  end

endmodule
